rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data ROM word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, data ROM address width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req0  input  1  requester 0 (CPU load path) access request.
REQ-006 The block SHALL have port addr0  input  ADDR_WIDTH  requester 0 ROM address.
REQ-007 The block SHALL have port req1  input  1  requester 1 (switch-index display lookup) access request.
REQ-008 The block SHALL have port addr1  input  ADDR_WIDTH  requester 1 ROM address.
REQ-009 The block SHALL have ports gnt0 and gnt1  output  1 each  grant to the requester whose access is in progress.
REQ-010 The block SHALL have ports rsp_valid0 and rsp_valid1  output  1 each  one-cycle read-data-valid pulse.
REQ-011 The block SHALL have port rsp_data  output  WIDTH  read data, shared by both requesters.
REQ-012 The block SHALL have port rom_addr  output  ADDR_WIDTH  registered address to the synchronous ROM.
REQ-013 The block SHALL have port rom_dout  input  WIDTH  ROM read data, valid one cycle after rom_addr changes.
REQ-014 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ADDR and DATA, with transitions IDLE->ADDR when any req is high, ADDR->DATA unconditionally, and DATA->IDLE unconditionally.
REQ-016 In IDLE with at least one req sampled high at edge N, the block SHALL register the winner's address into rom_addr and assert the winner's gnt from cycle N+1 until the end of DATA.
REQ-017 In DATA (cycle N+2), the block SHALL drive rsp_data = rom_dout and pulse the winner's rsp_valid high for exactly one cycle; req-to-rsp_valid latency is 2 cycles.
REQ-018 Throughput SHALL be one access per 3 cycles; a req still high in IDLE SHALL start a new access.
REQ-019 At most one gnt and at most one rsp_valid SHALL be high in any cycle.
REQ-020 If both reqs are high in IDLE, the block SHALL serve the requester not served last; a last-served pointer SHALL update on each IDLE->ADDR transition.
REQ-021 A single requesting port SHALL always win, regardless of the pointer.
REQ-022 If a req drops during ADDR or DATA, the block SHALL still complete the access and pulse rsp_valid; it SHALL NOT abort.
REQ-023 The block SHALL capture addr0 and addr1 only in IDLE; changes during ADDR or DATA SHALL be ignored.
REQ-024 rom_addr SHALL hold its last value in IDLE; the full address range 0..2^ADDR_WIDTH-1 SHALL pass through without wrap or modification.
REQ-025 When rsp_valid0 and rsp_valid1 are both low, rsp_data SHALL be 0.

Reset
REQ-026 While reset is high at a clock edge, the block SHALL set the state to IDLE; gnt0, gnt1, rsp_valid0, rsp_valid1 and busy to 0; rom_addr and rsp_data to 0; and the last-served pointer to port 1, so port 0 wins the first tie.
REQ-027 A reset asserted during ADDR or DATA SHALL discard the access, and no rsp_valid SHALL be issued for it.

Configuration
REQ-028 The macro ROM_ARB_RR_EN SHALL select the arbitration policy.
REQ-029 With ROM_ARB_RR_EN defined, ties SHALL be resolved round-robin as in REQ-020.
REQ-030 Without ROM_ARB_RR_EN, the block SHALL use fixed priority: port 0 wins every tie and the pointer logic is absent.

Structure
REQ-031 The shared package rom_arb_pkg SHALL hold the state enum typedef (IDLE, ADDR, DATA), the requester-id typedef (PORT0, PORT1) and the constant NUM_PORTS = 2.
REQ-032 The block SHALL contain one sub-module, rom_arb_pick, a purely combinational winner select taking req0, req1 and the pointer.
REQ-033 The ROM SHALL remain outside the block.

Verification
REQ-034 The bench SHALL cover: req0=1, addr0=0x05, ROM[0x05]=0xA3 -> gnt0 high at cycle 1, rom_addr=0x05 at cycle 1, rsp_valid0 with rsp_data=0xA3 at cycle 2, busy low at cycle 3.
REQ-035 The bench SHALL cover: req0 and req1 both held high from reset release, ROM_ARB_RR_EN defined -> grant order 0,1,0,1, one rsp every 3 cycles.
REQ-036 The bench SHALL cover: the same stimulus as REQ-035 without ROM_ARB_RR_EN -> only port 0 is ever served, and rsp_valid1 never pulses.
REQ-037 The bench SHALL cover: req1=1, addr1=0xFF, ROM[0xFF]=0x7E, with addr1 changed to 0x00 during ADDR -> rom_addr stays 0xFF and rsp_data=0x7E.
REQ-038 The bench SHALL cover: reset pulsed for one cycle while in ADDR -> no rsp_valid, all outputs 0 the next cycle, and a tie on the next request goes to port 0.
REQ-039 The bench SHALL cover: req0 dropped during DATA -> rsp_valid0 still pulses once, then the FSM returns to IDLE and stays idle.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM arbiter: FSM states, requester ids and port count.
// Imported by rom_arbiter, rom_arb_pick and the bench.
package rom_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    // One-hot grant vector for a single requester id.
    function automatic logic [NUM_PORTS-1:0] port_onehot(port_t p);
        logic [NUM_PORTS-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the ROM arbiter: two request/address pairs, grants,
// response strobes, the shared read data and the busy flag.
interface rom_arbiter_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  req0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic                  req1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rsp_valid0;
    logic                  rsp_valid1;
    logic [WIDTH-1:0]      rsp_data;
    logic                  busy;

    modport master (
        output req0, addr0, req1, addr1,
        input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, busy
    );

    modport slave (
        input  req0, addr0, req1, addr1,
        output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, busy
    );
endinterface

// File: rtl/rom_arb_pick.sv
// Combinational winner select for the two ROM requesters.
// A lone requester always wins; on a tie the port not served last wins.
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic  req0,
    input  logic  req1,
    input  port_t last_served,
    output logic  any_req,
    output port_t winner
);

    assign any_req = req0 | req1;

    // Holding last_served at PORT1 turns this into fixed priority for port 0.
    always_comb begin
        winner = PORT1;
        if (req0 && (!req1 || (last_served == PORT1))) begin
            winner = PORT0;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a synchronous ROM: one access per 3 cycles.
// Define ROM_ARB_RR_EN for round-robin ties; otherwise port 0 wins every tie.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
)
(
    input  logic                  clk,
    input  logic                  reset,
    rom_arbiter_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0]      rom_dout
);

    state_t                state_reg;
    logic [NUM_PORTS-1:0]  gnt_reg;
    logic [NUM_PORTS-1:0]  rsp_valid_reg;
    logic                  busy_reg;
    logic [ADDR_WIDTH-1:0] rom_addr_reg;
    logic [ADDR_WIDTH-1:0] rom_addr_next;
    port_t                 last_served;
    port_t                 winner;
    logic                  any_req;

    rom_arb_pick u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_served (last_served),
        .any_req     (any_req),
        .winner      (winner)
    );

    assign rom_addr_next = (winner == PORT0) ? bus.addr0 : bus.addr1;

`ifdef ROM_ARB_RR_EN
    port_t last_served_reg;

    // Reset to PORT1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_served_reg <= PORT1;
        end else if ((state_reg == IDLE) && any_req) begin
            last_served_reg <= winner;
        end
    end

    assign last_served = last_served_reg;
`else
    assign last_served = PORT1;
`endif

    // Addresses are captured only on the IDLE->ADDR edge; the access always
    // runs to completion unless reset discards it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            busy_reg      <= 1'b0;
            rom_addr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    rsp_valid_reg <= '0;
                    if (any_req) begin
                        state_reg    <= ADDR;
                        gnt_reg      <= port_onehot(winner);
                        busy_reg     <= 1'b1;
                        rom_addr_reg <= rom_addr_next;
                    end
                end
                ADDR: begin
                    state_reg     <= DATA;
                    rsp_valid_reg <= gnt_reg;
                end
                DATA: begin
                    state_reg     <= IDLE;
                    gnt_reg       <= '0;
                    rsp_valid_reg <= '0;
                    busy_reg      <= 1'b0;
                end
                default: begin
                    state_reg     <= IDLE;
                    gnt_reg       <= '0;
                    rsp_valid_reg <= '0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    // The ROM registers rom_addr during ADDR, so its output is live in DATA.
    assign bus.rsp_data   = (|rsp_valid_reg) ? rom_dout : '0;
    assign bus.gnt0       = gnt_reg[PORT0];
    assign bus.gnt1       = gnt_reg[PORT1];
    assign bus.rsp_valid0 = rsp_valid_reg[PORT0];
    assign bus.rsp_valid1 = rsp_valid_reg[PORT1];
    assign bus.busy       = busy_reg;
    assign rom_addr       = rom_addr_reg;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed, scoreboard-checked bench for rom_arbiter with a behavioural
// synchronous ROM; expectations follow ROM_ARB_RR_EN when it is defined.
module tb_rom_arbiter;
    import rom_arb_pkg::*;

    localparam int WIDTH = 8;
    localparam int AW    = 8;

    typedef struct {
        logic             port;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [AW-1:0]    rom_addr;
    logic [WIDTH-1:0] rom_dout;
    logic [WIDTH-1:0] rom_mem [256];

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rom_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

    rom_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout)
    );

    always @(posedge clk) rom_dout <= rom_mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"}, 32'(bus.gnt0), 32'd0);
        check({tag, "_gnt1"}, 32'(bus.gnt1), 32'd0);
        check({tag, "_rv0"}, 32'(bus.rsp_valid0), 32'd0);
        check({tag, "_rv1"}, 32'(bus.rsp_valid1), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    endtask

    // Scoreboard side: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid0 || bus.rsp_valid1) begin
            exp_t e;
            check("rsp_onehot", 32'(bus.rsp_valid0 & bus.rsp_valid1), 32'd0);
            check("rsp_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rsp_port", 32'(bus.rsp_valid1), 32'(e.port));
                check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                $display("rsp port=%0d data=0x%02h expected port=%0d data=0x%02h",
                         bus.rsp_valid1, bus.rsp_data, e.port, e.data);
            end
        end
    end

    initial begin
        logic exp_port;
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'((i * 7 + 3) ^ 8'h5A);
        rom_mem[8'h05] = 8'hA3;
        rom_mem[8'hFF] = 8'h7E;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        reset     = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");

        // Single request from port 0 at address 0x05.
        reset = 1'b0;
        bus.req0 = 1'b1;
        bus.addr0 = 8'h05;
        sb_q.push_back('{1'b0, rom_mem[8'h05]});
        tick();
        check("a_gnt0_c1", 32'(bus.gnt0), 32'd1);
        check("a_gnt1_c1", 32'(bus.gnt1), 32'd0);
        check("a_rom_addr_c1", 32'(rom_addr), 32'h05);
        check("a_busy_c1", 32'(bus.busy), 32'd1);
        bus.req0 = 1'b0;
        tick();
        check("a_rv0_c2", 32'(bus.rsp_valid0), 32'd1);
        check("a_data_c2", 32'(bus.rsp_data), 32'hA3);
        tick();
        check("a_busy_c3", 32'(bus.busy), 32'd0);
        check("a_rv0_c3", 32'(bus.rsp_valid0), 32'd0);
        check("a_data_c3", 32'(bus.rsp_data), 32'd0);

        // Port 1 at the top address; addr1 changes during ADDR.
        bus.req1 = 1'b1;
        bus.addr1 = 8'hFF;
        sb_q.push_back('{1'b1, rom_mem[8'hFF]});
        tick();
        check("d_gnt1", 32'(bus.gnt1), 32'd1);
        check("d_rom_addr_addr", 32'(rom_addr), 32'hFF);
        bus.addr1 = 8'h00;
        bus.req1 = 1'b0;
        tick();
        check("d_rom_addr_data", 32'(rom_addr), 32'hFF);
        check("d_rv1", 32'(bus.rsp_valid1), 32'd1);
        check("d_data", 32'(bus.rsp_data), 32'h7E);
        tick();
        check("d_rom_addr_idle", 32'(rom_addr), 32'hFF);

        // req0 dropped during DATA: access still completes, then stays idle.
        bus.req0 = 1'b1;
        bus.addr0 = 8'h10;
        sb_q.push_back('{1'b0, rom_mem[8'h10]});
        tick();
        tick();
        bus.req0 = 1'b0;
        check("f_rv0", 32'(bus.rsp_valid0), 32'd1);
        tick();
        check("f_busy_idle1", 32'(bus.busy), 32'd0);
        tick();
        check("f_busy_idle2", 32'(bus.busy), 32'd0);
        check("f_rv0_idle2", 32'(bus.rsp_valid0), 32'd0);

        // Reset pulsed during ADDR discards the access; next tie goes to port 0.
        bus.req0 = 1'b1;
        bus.addr0 = 8'h20;
        tick();
        check("e_busy_addr", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        bus.req0 = 1'b0;
        tick();
        check_all_zero("e_after_reset");
        reset = 1'b0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.addr0 = 8'h30;
        bus.addr1 = 8'h31;
        sb_q.push_back('{1'b0, rom_mem[8'h30]});
        tick();
        check("e_tie_gnt0", 32'(bus.gnt0), 32'd1);
        check("e_tie_gnt1", 32'(bus.gnt1), 32'd0);
        check("e_tie_rom_addr", 32'(rom_addr), 32'h30);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        tick();

        // Both requests held high from reset release: four back-to-back accesses.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.addr0 = 8'h40;
        bus.addr1 = 8'h41;
        for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_RR_EN
            exp_port = k[0];
`else
            exp_port = 1'b0;
`endif
            sb_q.push_back('{exp_port, rom_mem[exp_port ? 8'h41 : 8'h40]});
        end
        for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_RR_EN
            exp_port = k[0];
`else
            exp_port = 1'b0;
`endif
            tick();
            check("b_gnt0", 32'(bus.gnt0), 32'(!exp_port));
            check("b_gnt1", 32'(bus.gnt1), 32'(exp_port));
            tick();
            check("b_rv0", 32'(bus.rsp_valid0), 32'(!exp_port));
            check("b_rv1", 32'(bus.rsp_valid1), 32'(exp_port));
            tick();
            check("b_busy_gap", 32'(bus.busy), 32'd0);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        tick();
        check("end_busy", 32'(bus.busy), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
